alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 13-bit combinational ALU. Keeps the same 3-bit opcode map.
- Adds a registered result with a condition-flag output and valid/ready flow control on both sides.
- Shifts are multi-cycle, one bit per clock, so no barrel shifter is needed at wide WIDTH.
- Sits between the decode/operand-fetch stage and writeback in the datapath.

Parameters:
- WIDTH, 13: operand and result width in bits (minimum 2).
- CNT_W, $clog2(WIDTH+1): localparam, width of the shift counter; not user-overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B, or unsigned shift amount
- op  in  3  opcode: 000 add, 001 sub, 010 shr, 011 shl, 100 addi, 101 subi, 110 and, 111 or
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- flags  out  4  {N, Z, C, V}

Behaviour:
- Reset is asynchronous on the falling edge of rst_n. State goes to IDLE; out_valid=0, result=0, flags=0, shift counter=0. in_ready is 1 once reset is released and the block is in IDLE.
- States:
  - IDLE: waiting for a request.
  - SHIFT: iterative shift in progress.
  - OUT: result held until consumed.
- in_ready = (state==IDLE). A request is accepted on a rising edge where in_valid && in_ready. a, b and op are sampled only at acceptance.
- Non-shift ops (add, sub, addi, subi, and, or):
  - Result and flags are registered at the acceptance edge.
  - State goes to OUT; out_valid=1 on the next cycle (latency 1).
- Shift ops (shr, shl):
  - At acceptance: working reg = a, count = (b >= WIDTH) ? WIDTH : b, C cleared.
  - count==0: result=a, go to OUT directly (latency 1).
  - Otherwise go to SHIFT. Each cycle: shift the working reg by 1 (logical, zero fill), capture the bit shifted out into C, decrement count.
  - When count reaches 0: go to OUT. Latency = 1 + count cycles from the acceptance edge.
  - A shift amount >= WIDTH yields result 0 after WIDTH shifts.
- OUT:
  - out_valid=1. result and flags are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid goes to 0, state goes to IDLE.
  - in_ready goes high the cycle after the handshake; no same-cycle bypass, so throughput is at most 1 op per 2 cycles.
- Arithmetic is modulo 2^WIDTH. addi/subi behave identically to add/sub; the immediate is already placed in b by decode.
- Flags:
  - N = result[WIDTH-1]; Z = (result==0).
  - add: C = carry out of MSB; V = signed overflow (operand signs equal, result sign differs).
  - sub: C = 1 when no borrow (a >= b unsigned); V = signed overflow (operand signs differ, result sign differs from a).
  - shifts: C = last bit shifted out (0 if count==0); V = 0.
  - and/or: C = 0, V = 0.
- Boundary rules:
  - in_valid while not IDLE is ignored; the requester must hold it until in_ready.
  - Reset asserted mid-SHIFT or in OUT aborts the operation and drops the pending result.
  - Undefined opcode values are impossible (3-bit, fully decoded).

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_ADD..OP_OR with the encodings above
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - state encoding ST_IDLE, ST_SHIFT, ST_OUT
- Sub-module alu_addsub #(WIDTH): combinational a ± b producing sum, carry-out and overflow. Instantiated once and shared by add/sub/addi/subi.

Test Plan:
- Add wrap: op=000, a=0x1FFF, b=0x0001 -> result=0x0000, flags N0 Z1 C1 V0, out_valid exactly 1 cycle after acceptance.
- Sub borrow: op=001, a=5, b=7 -> result=0x1FFE, N1 Z0 C0 V0. Signed overflow check: op=000, a=0x0FFF, b=1 -> result=0x1000, N1 V1 C0.
- Shift latency: op=011, a=0x0001, b=4 -> result=0x0010, C0. out_valid rises 5 cycles after acceptance; in_ready low throughout.
- Shift saturation: op=011, a=0x0001, b=20 -> 13 shift cycles, result=0x0000, Z1 C1. Also op=010, a=0x1ABC, b=0 -> result=0x1ABC, latency 1, C0.
- Backpressure: out_ready held low 3 cycles after out_valid -> result/flags stable, in_ready stays 0. Raising out_ready completes the handshake; in_ready=1 on the following cycle.
- Reset mid-op: assert rst_n=0 during SHIFT (op=010, a=0x1000, b=10, after 3 cycles) -> out_valid=0 and result=0 immediately. After release, the block accepts a new add correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the sequential ALU slice: the 3-bit opcode map,
// the bit positions inside the 4-bit {N, Z, C, V} flag vector, the
// controller state encoding and a small opcode-class helper.
// No ports (package).
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_SUBI = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  // Shifts are the only multi-cycle operations.
  function automatic logic isShiftOp(input logic [2:0] opCode);
    return (opCode == OP_SHR) || (opCode == OP_SHL);
  endfunction

  // The immediate forms were already folded into b by decode, so only the
  // subtract direction matters to the adder.
  function automatic logic isSubOp(input logic [2:0] opCode);
    return (opCode == OP_SUB) || (opCode == OP_SUBI);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub
// Combinational WIDTH-bit adder/subtractor shared by add/sub/addi/subi.
// Ports:
//   a, b  in   operands
//   sub   in   1 = a - b, 0 = a + b
//   sum   out  a +/- b modulo 2^WIDTH
//   cout  out  carry out of the MSB (for subtract: 1 means no borrow)
//   ovf   out  two's-complement overflow
module alu_addsub #(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] bEff;
  logic [WIDTH:0]   full;

  // Subtraction is a + ~b + 1, so the carry out directly reads as
  // "no borrow". Overflow is then the same rule for both directions:
  // the effective operands agree in sign but the sum does not.
  always_comb begin
    bEff = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bEff} + {{WIDTH{1'b0}}, sub};
    sum  = full[WIDTH-1:0];
    cout = full[WIDTH];
    ovf  = (a[WIDTH-1] == bEff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq
// Handshaked, registered ALU. Single-cycle ops register result and flags at
// the accepting edge; shifts run one bit per clock through the result
// register so no barrel shifter is needed.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake (a, b, op sampled on acceptance)
//   a, b, op             operands and 3-bit opcode (b = shift amount)
//   out_valid/out_ready  result handshake
//   result, flags        registered result and {N, Z, C, V}
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int                CNT_W   = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]  WIDTH_B = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0]  WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           nextState;
  logic [CNT_W-1:0] shiftCnt;
  logic [CNT_W-1:0] startCnt;
  logic             shiftLeft;
  logic             accept;
  logic             startShift;
  logic [WIDTH-1:0] sumVal;
  logic             sumCout;
  logic             sumOvf;
  logic [WIDTH-1:0] comboRes;
  logic [3:0]       comboFlags;
  logic [WIDTH-1:0] shiftNext;
  logic             shiftOut;

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_OUT);
  assign accept     = in_valid && in_ready;
  assign startCnt   = (b >= WIDTH_B) ? WIDTH_C : b[CNT_W-1:0];
  assign startShift = isShiftOp(op) && (startCnt != '0);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (a),
    .b    (b),
    .sub  (isSubOp(op)),
    .sum  (sumVal),
    .cout (sumCout),
    .ovf  (sumOvf)
  );

  // Result and flags for everything that finishes at the accepting edge.
  // A shift by zero falls into the default arm: result = a with C and V
  // clear, which is exactly its defined outcome.
  always_comb begin
    comboRes   = a;
    comboFlags = '0;
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: begin
        comboRes           = sumVal;
        comboFlags[FLAG_C] = sumCout;
        comboFlags[FLAG_V] = sumOvf;
      end
      OP_AND:  comboRes = a & b;
      OP_OR:   comboRes = a | b;
      default: comboRes = a;
    endcase
    comboFlags[FLAG_N] = comboRes[WIDTH-1];
    comboFlags[FLAG_Z] = (comboRes == '0);
  end

  // One-bit logical shift of the working value (held in the result
  // register while shifting) plus the bit that falls off the end.
  always_comb begin
    shiftNext = shiftLeft ? {result[WIDTH-2:0], 1'b0} : {1'b0, result[WIDTH-1:1]};
    shiftOut  = shiftLeft ? result[WIDTH-1] : result[0];
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. SHIFT is only entered with a non-zero count, and it
  // leaves on the edge that performs the last shift, giving a total
  // latency of 1 + count from acceptance.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          nextState = startShift ? ST_SHIFT : ST_OUT;
        end
      end
      ST_SHIFT: begin
        if (shiftCnt == CNT_ONE) begin
          nextState = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          nextState = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Datapath registers. Nothing is written in OUT, which is what keeps
  // result and flags stable under backpressure. While shifting only C is
  // tracked; N and Z are settled from the final value on the last shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      flags     <= '0;
      shiftCnt  <= '0;
      shiftLeft <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shiftLeft <= (op == OP_SHL);
            if (startShift) begin
              result   <= a;
              flags    <= '0;
              shiftCnt <= startCnt;
            end else begin
              result   <= comboRes;
              flags    <= comboFlags;
              shiftCnt <= '0;
            end
          end
        end
        ST_SHIFT: begin
          result        <= shiftNext;
          flags[FLAG_C] <= shiftOut;
          shiftCnt      <= shiftCnt - CNT_ONE;
          if (shiftCnt == CNT_ONE) begin
            flags[FLAG_N] <= shiftNext[WIDTH-1];
            flags[FLAG_Z] <= (shiftNext == '0);
            flags[FLAG_V] <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
